// File: rtl/class_tb_pkg.sv
// Shared types for the adder result FIFO: result width and result word type.
package class_tb_pkg;
    localparam int WIDTH  = 8;
    localparam int DATA_W = WIDTH + 1;
    typedef logic [DATA_W-1:0] result_t;
endpackage

// File: rtl/adder_result_fifo_if.sv
// Adder-result FIFO bus: producer/consumer side (master) and FIFO side (slave).
// Stats ports exist only when ADDER_RESULT_FIFO_STATS_EN is defined.
interface adder_result_fifo_if #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              clr_ovf;
`ifdef ADDER_RESULT_FIFO_STATS_EN
    logic [DATA_W+7:0] stat_sum;
    logic [15:0]       stat_cnt;

    modport master (output valid_in, data_in, out_ready, clr_ovf,
                    input  out_valid, out_data, count, full, empty, overflow,
                           stat_sum, stat_cnt);
    modport slave  (input  valid_in, data_in, out_ready, clr_ovf,
                    output out_valid, out_data, count, full, empty, overflow,
                           stat_sum, stat_cnt);
`else
    modport master (output valid_in, data_in, out_ready, clr_ovf,
                    input  out_valid, out_data, count, full, empty, overflow);
    modport slave  (input  valid_in, data_in, out_ready, clr_ovf,
                    output out_valid, out_data, count, full, empty, overflow);
`endif
endinterface

// File: rtl/adder_result_fifo_ptr_ctrl.sv
// Pointer/occupancy control for the result FIFO: qualifies push/pop/drop and
// tracks read/write pointers and count.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic          out_ready,
    output logic          push,
    output logic          pop,
    output logic          drop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        pop   = out_ready & ~empty;
        push  = valid_in & (~full | pop);
        drop  = valid_in & full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through FIFO behind the adder, with sticky overflow on drops.
// Optional pop statistics under ADDER_RESULT_FIFO_STATS_EN.
module adder_result_fifo
    import class_tb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DATA_W = WIDTH + 1,
    parameter int DEPTH  = 4
) (
    input logic                clk,
    input logic                rst,
    adder_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          push, pop, drop, full, empty;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .valid_in (bus.valid_in),
        .out_ready(bus.out_ready),
        .push     (push),
        .pop      (pop),
        .drop     (drop),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Storage is intentionally not reset; output gating hides stale entries.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= bus.data_in;
    end

    logic overflow_q, overflow_d;
    logic [DATA_W-1:0] head;

    always_comb begin
        overflow_d = overflow_q;
        if (drop)             overflow_d = 1'b1;
        else if (bus.clr_ovf) overflow_d = 1'b0;
        head = empty ? '0 : mem_q[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = head;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;

`ifdef ADDER_RESULT_FIFO_STATS_EN
    logic [DATA_W+7:0] stat_sum_q, stat_sum_d;
    logic [15:0]       stat_cnt_q, stat_cnt_d;

    always_comb begin
        stat_sum_d = stat_sum_q;
        stat_cnt_d = stat_cnt_q;
        if (pop) begin
            stat_sum_d = stat_sum_q + {8'b0, head};
            if (stat_cnt_q != 16'hFFFF) stat_cnt_d = stat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_sum_q <= '0;
            stat_cnt_q <= '0;
        end else begin
            stat_sum_q <= stat_sum_d;
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign bus.stat_sum = stat_sum_q;
    assign bus.stat_cnt = stat_cnt_q;
`endif
endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: reference queue model, checks at negedge.
module tb_adder_result_fifo;
    import class_tb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    adder_result_fifo #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    result_t sb_q [$];
    logic    model_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: drive inputs, update the model, cross posedge,
    // then compare registered status at the following negedge.
    task automatic step(input logic vin, input result_t din, input logic rdy, input logic clr);
        logic    m_pop;
        logic    m_full;
        result_t exp_head;
        bus.valid_in  = vin;
        bus.data_in   = din;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        exp_head = (sb_q.size() != 0) ? sb_q[0] : '0;
        chk("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
        chk("out_data", 32'(bus.out_data), 32'(exp_head));
        m_full = (sb_q.size() == DEPTH);
        m_pop  = rdy && (sb_q.size() != 0);
        if (m_pop) void'(sb_q.pop_front());
        if (vin && (!m_full || m_pop)) sb_q.push_back(din);
        if (vin && m_full && !m_pop) model_ovf = 1'b1;
        else if (clr)                model_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("count", 32'(bus.count), 32'(sb_q.size()));
        chk("full", 32'(bus.full), 32'(sb_q.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(sb_q.size() == 0));
        chk("overflow", 32'(bus.overflow), 32'(model_ovf));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single result, not consumed: visible the next cycle.
        step(1'b1, 9'h1FE, 1'b0, 1'b0);
        chk("first_valid", 32'(bus.out_valid), 1);
        chk("first_data", 32'(bus.out_data), 32'h1FE);
        drain();

        // Fill, then overflow; drain yields 1..4 only.
        for (int i = 1; i <= 4; i++) step(1'b1, result_t'(i), 1'b0, 1'b0);
        step(1'b1, 9'd5, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 4);
        drain();
        chk("ovf_sticky", 32'(bus.overflow), 1);

        // Drop with clr_ovf in the same cycle: set wins; then clear alone.
        for (int i = 1; i <= 4; i++) step(1'b1, result_t'(i), 1'b0, 1'b0);
        step(1'b1, 9'd7, 1'b0, 1'b1);
        chk("set_wins", 32'(bus.overflow), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(bus.overflow), 0);

        // Full with simultaneous push and pop: no overflow, 6 is last out.
        step(1'b1, 9'd6, 1'b1, 1'b0);
        chk("fullpp_ovf", 32'(bus.overflow), 0);
        chk("fullpp_count", 32'(bus.count), 4);
        chk("fullpp_last", 32'(sb_q[DEPTH-1]), 6);
        drain();

        // Streaming: every value emerges one cycle later, pointers wrap.
        for (int i = 0; i < 10; i++) step(1'b1, result_t'(i), 1'b1, 1'b0);
        drain();

        // Reset mid-stream with three entries.
        for (int i = 0; i < 3; i++) step(1'b1, result_t'(10 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_data", 32'(bus.out_data), 0);
`ifdef ADDER_RESULT_FIFO_STATS_EN
        chk("rst_stat_sum", 32'(bus.stat_sum), 0);
        chk("rst_stat_cnt", 32'(bus.stat_cnt), 0);
`endif
        sb_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 9'd100, 1'b0, 1'b0);
        step(1'b1, 9'd200, 1'b0, 1'b0);
        step(1'b1, 9'd300, 1'b0, 1'b0);
        drain();
`ifdef ADDER_RESULT_FIFO_STATS_EN
        chk("stat_sum", 32'(bus.stat_sum), 600);
        chk("stat_cnt", 32'(bus.stat_cnt), 3);
`endif
        chk("end_empty", 32'(bus.empty), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Downstream stage of the pipelined `adder`. It captures every `valid_out`/`result` pulse into a small first-word-fall-through FIFO and presents the results on a ready/valid output, so a slower consumer can drain them. The adder has no backpressure, so results that arrive while the FIFO is full are dropped and flagged with a sticky overflow bit.

## Interface
- `WIDTH`, default 8: adder operand width.
- `DATA_W`, default `WIDTH+1`: result width, including the carry.
- `DEPTH`, default 4: number of FIFO entries; a power of two, ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  connected to adder `valid_out`.
- `data_in`  in  DATA_W  connected to adder `result`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  DATA_W  head entry; reads 0 when empty.
- `count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky drop flag.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Pop: `pop = out_valid & out_ready`. `out_valid` = !empty. Read pointer advances by 1 on pop.
- Push: `push = valid_in & (!full | pop)`. Writes `mem[wr_ptr]` and advances the write pointer.
- Drop: `valid_in & full & !pop` discards the data. It sets `overflow`, and `count` is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH, from DEPTH-1 to 0.
- `count` updates as +1 on push only, −1 on pop only, and is unchanged on both or neither.
- Simultaneous push and pop:
  - When full, both proceed and the FIFO stays full with no overflow.
  - When empty, there is no pop because `out_valid` = 0, so the push completes normally.
- No bypass: data pushed into an empty FIFO appears on `out_valid`/`out_data` the next cycle.
- Overflow flag:
  - `clr_ovf` clears `overflow`.
  - If a drop and `clr_ovf` occur in the same cycle, the set wins and `overflow` = 1.
- `out_data` = `mem[rd_ptr]` gated with `out_valid`. It holds stable while `out_valid & !out_ready`.

## Timing
- Reset, asynchronous and immediate:
  - read pointer = 0, write pointer = 0, `count` = 0;
  - `empty` = 1, `full` = 0, `overflow` = 0, `out_valid` = 0, `out_data` = 0.
- Memory contents are not reset. Output gating hides them.
- Latency from `valid_in` at edge N to `out_valid` is 1 cycle: output is visible after edge N, sampled at edge N+1.
- `full`, `empty` and `count` are registered and reflect all pushes and pops of the previous edge.
- Reset asserted mid-stream discards all entries. The first `valid_in` after release is stored at index 0.
- Sustained throughput is one push and one pop per cycle at any occupancy.

## Configuration
- Macro: `ADDER_RESULT_FIFO_STATS_EN`.
- Defined: adds two outputs.
  - `stat_sum` (DATA_W+8 bits) accumulates `out_data` on every pop and wraps modulo 2^(DATA_W+8).
  - `stat_cnt` (16 bits) counts pops and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

## Structure
- Shared package `class_tb_pkg` holds the `DATA_W` helper constant and a `result_t` typedef, `logic [DATA_W-1:0]`. The testbench scoreboard uses the same typedef.
- One sub-module, `fifo_ptr_ctrl`: owns the pointers, count, full/empty and push/pop qualification.
- The storage array, output gating and stats stay in the top level.

## Test plan
- Reset, then one `valid_in` with `data_in`=9'h1FE and `out_ready`=0 → next cycle `out_valid`=1, `out_data`=9'h1FE, `count`=1.
- Push 4 values (1,2,3,4) with `out_ready`=0, then push 5 → `full`=1, `overflow`=1, `count`=4. Draining yields 1,2,3,4 only.
- With the FIFO full, push 6 while popping → `overflow` stays 0, `count`=4, and the last entry read is 6.
- Continuous push/pop for 10 cycles with data 0..9 and `out_ready`=1 → output 0..9 in order, each one cycle late. Pointers wrap twice and `count` stays ≤1.
- Assert `clr_ovf` in the same cycle as a drop → `overflow`=1. Assert `clr_ovf` alone the following cycle → `overflow`=0.
- Assert `rst` with `count`=3 → `count`=0, `empty`=1 and `out_valid`=0 immediately, before the next edge. With STATS_EN defined, `stat_sum`=0 and `stat_cnt`=0. After 3 pops of 100, 200 and 300, `stat_sum`=600 and `stat_cnt`=3.
